// File: rtl/update_player_arc.sv
// Player/title object updater with a rise/hang/fall jump trajectory, airborne flag and landing pulse.
// Optional crouch pose is compiled in with `define DUCK_EN.
module update_player_arc #(
    parameter int TYPEW       = 4,
    parameter int XW          = 10,
    parameter int YW          = 10,
    parameter int WW          = 8,
    parameter int HW          = 8,
    parameter int PLAYER_TYPE = 1,
    parameter int TITLE_TYPE  = 0,
    parameter int PLAYER_X    = 40,
    parameter int GROUND_Y    = 400,
    parameter int PEAK_Y      = 300,
    parameter int PLAYER_W    = 32,
    parameter int PLAYER_H    = 40,
    parameter int TITLE_X     = 200,
    parameter int TITLE_Y     = 150,
    parameter int TITLE_W     = 240,
    parameter int TITLE_H     = 80,
    parameter int RISE_STEP   = 20,
    parameter int FALL_STEP   = 25,
    parameter int HANG_TICKS  = 3,
    parameter int DUCK_H      = 24
) (
    input  logic                             clk3,
    input  logic                             reset,
    input  logic                             pause,
    input  logic                             start,
    input  logic                             jump,
    input  logic                             duck,
    output logic [TYPEW+XW+YW+WW+HW-1:0]     player,
    output logic                             airborne,
    output logic                             landed
);

    // state  | meaning
    // TITLE  | title screen shown, player parked on the ground
    // RUN    | on the ground, waiting for a jump press
    // RISE   | moving up towards PEAK_Y
    // HANG   | held at the apex for HANG_TICKS ticks
    // FALL   | moving down towards GROUND_Y
    localparam logic [2:0] S_TITLE = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_RISE  = 3'd2;
    localparam logic [2:0] S_HANG  = 3'd3;
    localparam logic [2:0] S_FALL  = 3'd4;

    localparam int HCW = $clog2(HANG_TICKS + 1);

    logic [2:0]    r_state;
    logic [YW-1:0] r_y;
    logic [HCW-1:0] r_hang_cnt;
    logic          r_jump_q;
    logic          r_landed;

    logic          w_press;
    logic          w_ducking;
    logic [YW:0]   w_rise_gap;
    logic [YW:0]   w_fall_gap;
    logic [YW-1:0] w_y_out;
    logic [HW-1:0] w_h_out;

    assign w_press    = r_jump_q & ~jump;
    assign w_rise_gap = {1'b0, r_y} - (YW+1)'(PEAK_Y);
    assign w_fall_gap = (YW+1)'(GROUND_Y) - {1'b0, r_y};

`ifdef DUCK_EN
    assign w_ducking = duck & (r_state == S_RUN);
`else
    logic w_unused_duck;
    assign w_unused_duck = duck;
    assign w_ducking     = 1'b0;
`endif

    always_ff @(posedge clk3) begin
        if (!reset) begin
            r_state    <= S_TITLE;
            r_y        <= YW'(GROUND_Y);
            r_hang_cnt <= '0;
            r_jump_q   <= 1'b1;
            r_landed   <= 1'b0;
        end else begin
            r_jump_q <= jump;
            r_landed <= 1'b0;
            if (!start) begin
                // Leaving the game aborts any jump in progress.
                r_state    <= S_TITLE;
                r_y        <= YW'(GROUND_Y);
                r_hang_cnt <= '0;
            end else if (!pause) begin
                case (r_state)
                    S_TITLE: r_state <= S_RUN;
                    S_RUN: begin
                        if (w_press && !w_ducking) r_state <= S_RISE;
                    end
                    S_RISE: begin
                        if (w_rise_gap <= (YW+1)'(RISE_STEP)) begin
                            r_y        <= YW'(PEAK_Y);
                            r_state    <= S_HANG;
                            r_hang_cnt <= '0;
                        end else begin
                            r_y <= r_y - YW'(RISE_STEP);
                        end
                    end
                    S_HANG: begin
                        if (r_hang_cnt == HCW'(HANG_TICKS - 1)) begin
                            r_state    <= S_FALL;
                            r_hang_cnt <= '0;
                        end else begin
                            r_hang_cnt <= r_hang_cnt + 1'b1;
                        end
                    end
                    S_FALL: begin
                        if (w_fall_gap <= (YW+1)'(FALL_STEP)) begin
                            r_y      <= YW'(GROUND_Y);
                            r_state  <= S_RUN;
                            r_landed <= 1'b1;
                        end else begin
                            r_y <= r_y + YW'(FALL_STEP);
                        end
                    end
                    default: r_state <= S_TITLE;
                endcase
            end
        end
    end

    always_comb begin
        w_y_out = r_y;
        w_h_out = HW'(PLAYER_H);
        if (w_ducking) begin
            // Shorter sprite keeps its feet on the ground line.
            w_y_out = YW'(GROUND_Y + PLAYER_H - DUCK_H);
            w_h_out = HW'(DUCK_H);
        end
    end

    always_comb begin
        if (r_state == S_TITLE) begin
            player = {HW'(TITLE_H), WW'(TITLE_W), YW'(TITLE_Y), XW'(TITLE_X), TYPEW'(TITLE_TYPE)};
        end else begin
            player = {w_h_out, WW'(PLAYER_W), w_y_out, XW'(PLAYER_X), TYPEW'(PLAYER_TYPE)};
        end
    end

    assign airborne = (r_state == S_RISE) || (r_state == S_HANG) || (r_state == S_FALL);
    assign landed   = r_landed;

endmodule

// File: tb/tb_update_player_arc.sv
// Scoreboard bench for update_player_arc: a behavioural model pushes expected outputs per tick,
// which are popped and compared after each clock edge. Honours `define DUCK_EN like the design.
module tb_update_player_arc;

    localparam int G  = 400;
    localparam int P  = 300;
    localparam int RS = 20;
    localparam int FS = 25;
    localparam int HT = 3;

    logic        clk3 = 1'b0;
    logic        reset = 1'b0;
    logic        pause = 1'b0;
    logic        start = 1'b0;
    logic        jump  = 1'b1;
    logic        duck  = 1'b0;
    logic [39:0] player;
    logic        airborne;
    logic        landed;

    typedef struct {
        int typ;
        int x;
        int y;
        int w;
        int h;
        int air;
        int land;
    } exp_t;

    exp_t exp_q[$];
    int   y_cap[$];
    bit   cap_en = 0;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: 0 TITLE, 1 RUN, 2 RISE, 3 HANG, 4 FALL
    int m_st = 0, m_y = G, m_h = 0, m_jq = 1, m_land = 0;

    update_player_arc dut (
        .clk3     (clk3),
        .reset    (reset),
        .pause    (pause),
        .start    (start),
        .jump     (jump),
        .duck     (duck),
        .player   (player),
        .airborne (airborne),
        .landed   (landed)
    );

    always #5 clk3 = ~clk3;

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_step();
        int  press;
        bit  ducking;
        exp_t e;
        press   = (m_jq == 1 && jump == 1'b0) ? 1 : 0;
`ifdef DUCK_EN
        ducking = (m_st == 1) && duck;
`else
        ducking = 0;
`endif
        m_land = 0;
        if (!reset) begin
            m_st = 0; m_y = G; m_h = 0; m_jq = 1;
        end else begin
            m_jq = int'(jump);
            if (!start) begin
                m_st = 0; m_y = G; m_h = 0;
            end else if (!pause) begin
                case (m_st)
                    0: m_st = 1;
                    1: if (press == 1 && !ducking) m_st = 2;
                    2: if (m_y - P <= RS) begin m_y = P; m_st = 3; m_h = 0; end
                       else m_y = m_y - RS;
                    3: if (m_h == HT - 1) begin m_st = 4; m_h = 0; end
                       else m_h = m_h + 1;
                    4: if (G - m_y <= FS) begin m_y = G; m_st = 1; m_land = 1; end
                       else m_y = m_y + FS;
                    default: m_st = 0;
                endcase
            end
        end
        // expected outputs after the edge; duck input is still the value driven now
        if (m_st == 0) begin
            e = '{typ: 0, x: 200, y: 150, w: 240, h: 80, air: 0, land: m_land};
        end else begin
            e = '{typ: 1, x: 40, y: m_y, w: 32, h: 40, air: (m_st >= 2) ? 1 : 0, land: m_land};
`ifdef DUCK_EN
            if (m_st == 1 && duck) begin
                e.y = G + 40 - 24;
                e.h = 24;
            end
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic rst_v, input logic st_v, input logic pa_v,
                        input logic jp_v, input logic dk_v);
        exp_t e;
        @(negedge clk3);
        reset = rst_v; start = st_v; pause = pa_v; jump = jp_v; duck = dk_v;
        model_step();
        @(posedge clk3);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("type",     int'(player[3:0]),   e.typ);
            chk("x",        int'(player[13:4]),  e.x);
            chk("y",        int'(player[23:14]), e.y);
            chk("width",    int'(player[31:24]), e.w);
            chk("height",   int'(player[39:32]), e.h);
            chk("airborne", int'(airborne),      e.air);
            chk("landed",   int'(landed),        e.land);
        end
        if (cap_en) y_cap.push_back(int'(player[23:14]) + (int'(landed) << 12));
    endtask

    task automatic run(input int n, input logic st_v, input logic pa_v, input logic jp_v);
        for (int i = 0; i < n; i++) tick(1'b1, st_v, pa_v, jp_v, 1'b0);
    endtask

    int exp_traj[14];

    initial begin
        // reset held, title screen
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b1);

        // basic jump; trajectory also checked against a hand-written table (bit 12 = landed)
        exp_traj = '{400, 380, 360, 340, 320, 300, 300, 300, 300, 325, 350, 375, 400 + 4096, 400};
        cap_en = 1;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run(13, 1'b1, 1'b0, 1'b1);
        cap_en = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < y_cap.size()) chk("trajectory", y_cap[i], exp_traj[i]);
            else chk("trajectory_len", y_cap.size(), 14);
        end

        // pause at y=340 while rising, with a press lost during pause
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0, 1'b1);
        run(2, 1'b1, 1'b1, 1'b1);
        run(1, 1'b1, 1'b1, 1'b0);
        run(2, 1'b1, 1'b1, 1'b1);
        run(14, 1'b1, 1'b0, 1'b1);

        // jump held low through the arc with extra presses airborne
        run(8, 1'b1, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0, 1'b1);
        run(3, 1'b1, 1'b0, 1'b0);
        run(4, 1'b1, 1'b0, 1'b1);
        run(3, 1'b1, 1'b0, 1'b1);

        // abort while falling at y=325, then restart
        run(1, 1'b1, 1'b0, 1'b0);
        run(9, 1'b1, 1'b0, 1'b1);
        run(1, 1'b0, 1'b0, 1'b1);
        run(3, 1'b1, 1'b0, 1'b1);

        // press on the landing edge is not seen, press on first RUN tick is accepted
        run(1, 1'b1, 1'b0, 1'b0);
        run(11, 1'b1, 1'b0, 1'b1);
        run(1, 1'b1, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0, 1'b1);
        run(1, 1'b1, 1'b0, 1'b0);
        run(16, 1'b1, 1'b0, 1'b1);

        // duck held in RUN with a press attempt
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        run(16, 1'b1, 1'b0, 1'b1);

        // random mix
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
